// File: rtl/fifo_d0_d1.sv
// fifo_d0_d1 -- two independent circular FIFOs that buffer the lane outputs
// of the upstream Demux_D0_D1 block. Each lane has its own pop interface.
//
// Ports
//   clk, reset                : single clock, synchronous active-high reset
//   valid_0/dataout0          : lane 0 push request / data
//   valid_1/dataout1          : lane 1 push request / data
//   pop_0, pop_1              : per-lane read requests
//   data_out0/1, valid_out0/1 : registered read data, 1-cycle latency
//   full_x, empty_x           : count == DEPTH / count == 0
//   almost_full_x             : count >= AF_THR
//   almost_empty_x            : count <= AE_THR
//   pause                     : almost_full_0 | almost_full_1
//   err_0, err_1              : sticky overflow/underflow flags, present only
//                               when the FIFO_ERR_EN macro is defined

module fifo_d0_d1_lane #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int AF_THR = 6,
    parameter int AE_THR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_vld,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
`ifdef FIFO_ERR_EN
    output logic              almost_empty,
    output logic              err
`else
    output logic              almost_empty
`endif
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THR);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THR);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              pop_ok, push_ok;

    // A full lane still accepts a push when a pop frees a slot on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Storage is never cleared; reset only discards it through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !reset)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
            pop_vld  <= 1'b0;
        end else begin
            pop_vld <= pop_ok;
            if (pop_ok) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

`ifdef FIFO_ERR_EN
    // A pop on an empty lane that is covered by a simultaneous push is a
    // normal startup case, not an underflow.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if ((push && !push_ok) || (pop && empty && !push))
            err <= 1'b1;
    end
`endif
endmodule

module fifo_d0_d1 #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int AF_THR = 6,
    parameter int AE_THR = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] dataout0,
    input  logic              valid_1,
    input  logic [DATA_W-1:0] dataout1,
    input  logic              pop_0,
    input  logic              pop_1,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              full_0,
    output logic              full_1,
    output logic              empty_0,
    output logic              empty_1,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              almost_empty_0,
    output logic              almost_empty_1,
`ifdef FIFO_ERR_EN
    output logic              pause,
    output logic              err_0,
    output logic              err_1
`else
    output logic              pause
`endif
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]             lane_push, lane_pop, lane_vld;
    logic [NUM_LANES-1:0]             lane_full, lane_empty, lane_af, lane_ae;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_wdata, lane_rdata;
`ifdef FIFO_ERR_EN
    logic [NUM_LANES-1:0]             lane_err;
`endif

    assign lane_push  = {valid_1, valid_0};
    assign lane_pop   = {pop_1, pop_0};
    assign lane_wdata = {dataout1, dataout0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        fifo_d0_d1_lane #(
            .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
            .AF_THR(AF_THR), .AE_THR(AE_THR)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .push        (lane_push[i]),
            .push_data   (lane_wdata[i]),
            .pop         (lane_pop[i]),
            .pop_data    (lane_rdata[i]),
            .pop_vld     (lane_vld[i]),
            .full        (lane_full[i]),
            .empty       (lane_empty[i]),
            .almost_full (lane_af[i]),
`ifdef FIFO_ERR_EN
            .almost_empty(lane_ae[i]),
            .err         (lane_err[i])
`else
            .almost_empty(lane_ae[i])
`endif
        );
    end

    assign data_out0      = lane_rdata[0];
    assign data_out1      = lane_rdata[1];
    assign valid_out0     = lane_vld[0];
    assign valid_out1     = lane_vld[1];
    assign full_0         = lane_full[0];
    assign full_1         = lane_full[1];
    assign empty_0        = lane_empty[0];
    assign empty_1        = lane_empty[1];
    assign almost_full_0  = lane_af[0];
    assign almost_full_1  = lane_af[1];
    assign almost_empty_0 = lane_ae[0];
    assign almost_empty_1 = lane_ae[1];
    assign pause          = |lane_af;
`ifdef FIFO_ERR_EN
    assign err_0          = lane_err[0];
    assign err_1          = lane_err[1];
`endif
endmodule

// File: tb/tb_fifo_d0_d1.sv
// Randomized + directed bench for fifo_d0_d1. The driver updates a queue
// model of each lane and pushes the expected registered read response into
// a scoreboard; a monitor pops and compares after every clock edge.
module tb_fifo_d0_d1;
    localparam int DW = 6;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic valid_0 = 1'b0, valid_1 = 1'b0, pop_0 = 1'b0, pop_1 = 1'b0;
    logic [DW-1:0] dataout0 = '0, dataout1 = '0;
    logic [DW-1:0] data_out0, data_out1;
    logic valid_out0, valid_out1;
    logic full_0, full_1, empty_0, empty_1;
    logic almost_full_0, almost_full_1, almost_empty_0, almost_empty_1, pause;
`ifdef FIFO_ERR_EN
    logic err_0, err_1;
    bit   merr [2];
`endif

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mq [2][$];   // model contents per lane
    exp_t          eq [2][$];   // expected read response per lane per edge
    logic [DW-1:0] mlast [2];   // model of held data_out

    fifo_d0_d1 dut (
        .clk(clk), .reset(reset),
        .valid_0(valid_0), .dataout0(dataout0),
        .valid_1(valid_1), .dataout1(dataout1),
        .pop_0(pop_0), .pop_1(pop_1),
        .data_out0(data_out0), .data_out1(data_out1),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .full_0(full_0), .full_1(full_1),
        .empty_0(empty_0), .empty_1(empty_1),
        .almost_full_0(almost_full_0), .almost_full_1(almost_full_1),
        .almost_empty_0(almost_empty_0), .almost_empty_1(almost_empty_1),
`ifdef FIFO_ERR_EN
        .pause(pause), .err_0(err_0), .err_1(err_1)
`else
        .pause(pause)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Flags are decoded from the current occupancy of the model.
    task automatic check_flags();
        int n0, n1;
        n0 = mq[0].size();
        n1 = mq[1].size();
        chk("flags0", {4'b0, full_0, empty_0, almost_full_0, almost_empty_0},
            {4'b0, n0 == DEPTH, n0 == 0, n0 >= 6, n0 <= 2});
        chk("flags1", {4'b0, full_1, empty_1, almost_full_1, almost_empty_1},
            {4'b0, n1 == DEPTH, n1 == 0, n1 >= 6, n1 <= 2});
        chk("pause", {7'b0, pause}, {7'b0, (n0 >= 6) || (n1 >= 6)});
`ifdef FIFO_ERR_EN
        chk("err", {6'b0, err_1, err_0}, {6'b0, merr[1], merr[0]});
`endif
    endtask

    task automatic lane_model(input int l, input bit rst, input bit v,
                              input logic [DW-1:0] d, input bit p);
        bit pop_ok, push_ok;
        exp_t e;
        if (rst) begin
            mq[l].delete();
            mlast[l] = '0;
`ifdef FIFO_ERR_EN
            merr[l] = 1'b0;
`endif
            e.v = 1'b0;
            e.d = '0;
        end else begin
            pop_ok  = p && (mq[l].size() > 0);
            push_ok = v && ((mq[l].size() < DEPTH) || pop_ok);
`ifdef FIFO_ERR_EN
            if ((v && !push_ok) || (p && mq[l].size() == 0 && !v)) merr[l] = 1'b1;
`endif
            if (pop_ok) mlast[l] = mq[l].pop_front();
            if (push_ok) mq[l].push_back(d);
            e.v = pop_ok;
            e.d = mlast[l];
        end
        eq[l].push_back(e);
    endtask

    // One clock: check state at the negedge, drive, model, wait for the edge.
    task automatic cyc(input bit rst, input bit v0, input logic [DW-1:0] d0,
                       input bit v1, input logic [DW-1:0] d1, input bit p0, input bit p1);
        @(negedge clk);
        check_flags();
        reset = rst;
        valid_0 = v0; dataout0 = d0; pop_0 = p0;
        valid_1 = v1; dataout1 = d1; pop_1 = p1;
        lane_model(0, rst, v0, d0, p0);
        lane_model(1, rst, v1, d1, p1);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq[0].size() != 0) begin
                e = eq[0].pop_front();
                chk("rd0", {1'b0, valid_out0, data_out0}, {1'b0, e.v, e.d});
            end
            if (eq[1].size() != 0) begin
                e = eq[1].pop_front();
                chk("rd1", {1'b0, valid_out1, data_out1}, {1'b0, e.v, e.d});
            end
        end
    end

    initial begin : driver
        mlast[0] = '0;
        mlast[1] = '0;
        // 1. reset
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 2. basic push/pop on both lanes
        cyc(0, 1, 6'h32, 1, 6'h12, 0, 0);
        cyc(0, 1, 6'h37, 1, 6'h13, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 3. fill lane 0, overflow, drain
        for (int i = 0; i < 8; i++) cyc(0, 1, 6'(i), 0, 0, 0, 0);
        cyc(0, 1, 6'h3F, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);          // underflow
        // 4. lane 1 full with simultaneous push/pop, then drain across wrap
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 6'(8 + i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 6'h25, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        // 5. empty lane 0 with push and pop together
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 6'h2D, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // 6. reset mid-stream with a pop pending
        cyc(0, 1, 6'h23, 0, 0, 0, 0);
        cyc(0, 1, 6'h04, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 6'h11, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // random traffic with slowly drifting push/pop bias
        for (int i = 0; i < 600; i++) begin
            int pb;
            pb = ((i / 50) % 2 == 0) ? 3 : 1;
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) < pb), 6'($urandom),
                ($urandom_range(0, 3) < 4 - pb), 6'($urandom),
                ($urandom_range(0, 3) < 4 - pb), ($urandom_range(0, 3) < pb));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_flags();
        chk("sb_drained", 8'(eq[0].size() + eq[1].size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
